imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 20, SHALL be the number of 32-bit instruction memory words; legal load length is 1..DEPTH.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, SHALL be the byte value that opens a load frame.
REQ-003 Parameter TIMEOUT, default 100000, SHALL be the maximum number of CLK cycles allowed between received bytes inside a frame.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 rx_valid  input  1  SHALL be a one-cycle strobe marking a received UART byte.
REQ-007 rx_data  input  8  SHALL be the received byte, valid when rx_valid=1.
REQ-008 core_pc  input  32  SHALL be the core program counter (byte address).
REQ-009 imem_we  output  1  SHALL be the instruction memory write enable.
REQ-010 imem_addr  output  32  SHALL be the instruction memory byte address.
REQ-011 imem_wd  output  32  SHALL be the instruction memory write data.
REQ-012 core_hold  output  1  SHALL hold the core in stall/reset while a load is in progress.
REQ-013 load_done  output  1  SHALL pulse for one cycle when a frame completes successfully.
REQ-014 load_err  output  1  SHALL be a sticky error flag, cleared when the next SYNC_BYTE is accepted.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, length byte N, then N words of 4 bytes each, least-significant byte first.
REQ-016 The FSM SHALL have the states IDLE, LEN, DATA, WRITE, DONE.
REQ-017 IDLE -> LEN on rx_valid with rx_data==SYNC_BYTE; all other bytes SHALL be ignored in IDLE.
REQ-018 LEN: on rx_valid with 1<=rx_data<=DEPTH, the FSM SHALL store N, clear word index and byte count, and go to DATA; otherwise it SHALL set load_err and return to IDLE.
REQ-019 DATA: each rx_valid SHALL shift the byte into lane byte_cnt (0..3) of the assembly register; the 4th byte SHALL go to WRITE.
REQ-020 WRITE (exactly one cycle): imem_we=1, imem_addr={word_idx,2'b00}, imem_wd=assembled word; then word_idx+1, and the FSM SHALL go to DONE if word_idx+1==N, else to DATA.
REQ-021 DONE (exactly one cycle): load_done=1, then the FSM SHALL go to IDLE.
REQ-022 core_hold SHALL be 1 in LEN, DATA, WRITE and DONE, and 0 in IDLE.
REQ-023 imem_addr SHALL equal core_pc when core_hold=0 and the loader address otherwise; imem_we SHALL be 0 outside WRITE.
REQ-024 An rx_valid during WRITE or DONE SHALL be dropped and SHALL set load_err; the frame SHALL continue.
REQ-025 Timeout counter SHALL clear on every rx_valid and on entry to LEN; reaching TIMEOUT in LEN or DATA SHALL set load_err and return to IDLE, leaving already-written words in memory.
REQ-026 A SYNC_BYTE received inside DATA SHALL be treated as data, not as a restart.
REQ-027 word_idx SHALL be $clog2(DEPTH) bits wide and SHALL never exceed DEPTH-1; byte_cnt SHALL be 2 bits wide.

Reset
REQ-028 On RST, the block SHALL asynchronously enter IDLE with counters, the assembly register, load_err, load_done and imem_we all at 0, so core_hold=0 and imem_addr follows core_pc.
REQ-029 An RST asserted mid-frame SHALL abort the frame immediately, with no further writes.

Structure
REQ-030 State encoding and the SYNC_BYTE and DEPTH defaults SHALL reside in the shared package used by the core top level.
REQ-031 The inter-byte timeout counter SHALL be a sub-module named loader_timeout (inputs: clear, enable; output: expired).

Verification
REQ-032 Send A5, 01, 13 00 00 00 -> exactly one cycle with imem_we=1, addr 0x0, wd 0x00000013; then load_done pulses once and core_hold falls.
REQ-033 Send A5, 14 (20 words), incrementing data -> 20 writes to addresses 0x00..0x4C; imem_addr = core_pc afterwards.
REQ-034 Send A5, 00 and A5, 15 -> load_err=1, no imem_we, FSM back in IDLE; a following A5 clears load_err.
REQ-035 Send A5, 02, then 4 bytes, then silence for TIMEOUT cycles -> one write at 0x0, then load_err=1 and core_hold=0.
REQ-036 Assert RST after 2 data bytes -> outputs at reset values at once; a new full frame afterwards loads correctly.
REQ-037 Send rx_valid in the WRITE cycle -> load_err=1, the byte is dropped, and remaining words are written at the correct addresses.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned DEPTH_DEF   = 20;
  localparam logic [7:0]  SYNC_DEF    = 8'hA5;
  localparam int unsigned TIMEOUT_DEF = 100000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } ld_state_e;

  // Width of a word index able to address 0..depth-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a framed UART byte stream while holding the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] core_pc,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned IW      = idx_width(DEPTH);
  localparam int unsigned NW      = $clog2(DEPTH + 1);
  localparam logic [8:0]  DEPTH_B = 9'(DEPTH);

  ld_state_e         state_q;
  logic [IW-1:0]     word_idx_q;
  logic [NW-1:0]     n_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       asm_q;
  logic              err_q;

  logic              len_ok;
  logic              last_word;
  logic              tmo_clear;
  logic              tmo_en;
  logic              tmo_expired;

  assign len_ok    = (rx_data != 8'd0) && ({1'b0, rx_data} <= DEPTH_B);
  assign last_word = ((NW'(word_idx_q) + NW'(1)) == n_q);

  // Idle clearing keeps a stale count from leaking into the next frame.
  assign tmo_clear = rx_valid || (state_q == IDLE);
  assign tmo_en    = (state_q == LEN) || (state_q == DATA);

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // Frame FSM: sync, length, byte assembly, one-cycle write, one-cycle done.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      n_q        <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            err_q   <= 1'b0;
            state_q <= LEN;
          end
        end
        LEN: begin
          if (rx_valid) begin
            if (len_ok) begin
              n_q        <= NW'(rx_data);
              word_idx_q <= '0;
              byte_cnt_q <= '0;
              state_q    <= DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (rx_valid) begin
            asm_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= WRITE;
            end
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        WRITE: begin
          if (rx_valid) begin
            err_q <= 1'b1;
          end
          // The index is not advanced past the final word so it stays within DEPTH-1.
          if (last_word) begin
            state_q <= DONE;
          end else begin
            word_idx_q <= word_idx_q + 1'b1;
            state_q    <= DATA;
          end
        end
        DONE: begin
          if (rx_valid) begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    imem_we   = (state_q == WRITE);
    load_done = (state_q == DONE);
    core_hold = (state_q != IDLE);
    load_err  = err_q;
    imem_wd   = asm_q;
    imem_addr = core_hold ? {{(32 - IW - 2){1'b0}}, word_idx_q, 2'b00} : core_pc;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus corner-case sequences.
module tb_imem_loader;

  localparam int unsigned DEPTH = 20;
  localparam int          TMO   = 40;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] core_pc = 32'h0000_1000;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  always #5 CLK = ~CLK;

  imem_loader #(
    .DEPTH     (DEPTH),
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .core_pc   (core_pc),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] len;
    bit         exp_err;
    bit         incr;
  } vec_t;

  wr_t  sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Free-running program counter, updated away from the sampling points.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      core_pc = core_pc + 32'd4;
    end
  end

  // Scoreboard and pass-through monitor.
  wr_t e;
  always @(negedge CLK) begin
    if (!RST) begin
      if (load_done) done_cnt++;
      if (imem_we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, no write required", imem_addr, imem_wd);
        end else begin
          e = sb.pop_front();
          chk("write_addr", imem_addr, e.addr);
          chk("write_data", imem_wd, e.data);
        end
      end
      if (!core_hold) chk("idle_addr", imem_addr, core_pc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input int unsigned idx, input logic [31:0] w);
    sb.push_back({32'(idx * 4), w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (core_hold && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(core_hold), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    logic [31:0] w;

    tbl[0] = '{8'h01, 1'b0, 1'b0};
    tbl[1] = '{8'h14, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h15, 1'b1, 1'b0};
    tbl[4] = '{8'h02, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h03, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_hold", 32'(core_hold), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_addr", imem_addr, core_pc);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Stray bytes in IDLE are ignored
    send_byte(8'h13);
    send_byte(8'h01);
    @(negedge CLK);
    chk("idle_ignore_hold", 32'(core_hold), 32'd0);
    chk("idle_ignore_err", 32'(load_err), 32'd0);

    // Table of frames
    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt;
      send_byte(SYNC);
      chk("tbl_sync_err_clear", 32'(load_err), 32'd0);
      chk("tbl_sync_hold", 32'(core_hold), 32'd1);
      send_byte(tbl[v].len);
      if (!tbl[v].exp_err) begin
        for (int unsigned k = 0; k < 32'(tbl[v].len); k++) begin
          w = tbl[v].incr ? 32'(k) : $urandom();
          send_word(k, w);
        end
      end
      wait_idle("tbl_idle_bound");
      @(negedge CLK);
      chk("tbl_err", 32'(load_err), 32'(tbl[v].exp_err));
      chk("tbl_done_pulses", 32'(done_cnt - d0), tbl[v].exp_err ? 32'd0 : 32'd1);
      chk("tbl_sb_empty", 32'(sb.size()), 32'd0);
    end

    // Byte arriving during the WRITE cycle is dropped and flagged
    d0 = done_cnt;
    send_byte(SYNC);
    send_byte(8'h02);
    w = 32'hDEAD_BEEF;
    sb.push_back({32'h0, w});
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
    @(posedge CLK);
    #1;
    rx_valid = 1'b1;
    rx_data  = w[31:24];
    @(posedge CLK);
    #1;
    rx_data  = 8'h77;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    chk("coll_err", 32'(load_err), 32'd1);
    chk("coll_hold", 32'(core_hold), 32'd1);
    send_word(1, 32'h0BAD_F00D);
    wait_idle("coll_idle_bound");
    @(negedge CLK);
    chk("coll_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("coll_err_sticky", 32'(load_err), 32'd1);
    chk("coll_sb_empty", 32'(sb.size()), 32'd0);

    // Inter-byte timeout after one of two words
    d0 = done_cnt;
    send_byte(SYNC);
    chk("tmo_sync_err_clear", 32'(load_err), 32'd0);
    send_byte(8'h02);
    send_word(0, 32'h1234_5678);
    n = 0;
    while (!load_err && n < TMO + 20) begin
      @(negedge CLK);
      n++;
    end
    chk("tmo_err", 32'(load_err), 32'd1);
    chk("tmo_not_early", 32'(n >= TMO - 2), 32'd1);
    chk("tmo_not_late", 32'(n <= TMO + 6), 32'd1);
    @(negedge CLK);
    chk("tmo_hold", 32'(core_hold), 32'd0);
    chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    chk("tmo_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a frame
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #2;
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_hold", 32'(core_hold), 32'd0);
    chk("midrst_done", 32'(load_done), 32'd0);
    chk("midrst_err", 32'(load_err), 32'd0);
    chk("midrst_addr", imem_addr, core_pc);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    d0 = done_cnt;
    send_byte(SYNC);
    send_byte(8'h01);
    send_word(0, 32'hCAFE_F00D);
    wait_idle("midrst_idle_bound");
    @(negedge CLK);
    chk("midrst_reload_done", 32'(done_cnt - d0), 32'd1);
    chk("midrst_reload_err", 32'(load_err), 32'd0);
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
